// File: rtl/iterative_round_engine_pkg.sv
// Shared AES definitions for the iterative round engine: block/key types, FSM encoding,
// legal round counts, S-box tables and the byte/column transforms used by a round.
package iterative_round_engine_pkg;

  typedef logic [127:0] state_t;
  typedef logic [127:0] roundKey_t;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} engine_fsm_t;

  localparam int AES128_ROUNDS = 10;
  localparam int AES192_ROUNDS = 12;
  localparam int AES256_ROUNDS = 14;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Byte i of a block is FIPS byte order: byte 0 is the most significant.
  function automatic logic [7:0] get_byte(input state_t s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic state_t sub_bytes(input state_t s);
    state_t r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = SBOX[get_byte(s, i)];
    return r;
  endfunction

  function automatic state_t inv_sub_bytes(input state_t s);
    state_t r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = INV_SBOX[get_byte(s, i)];
    return r;
  endfunction

  // Column-major layout: row r of column c lives in byte r+4c.
  function automatic state_t shift_rows(input state_t s);
    state_t r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(w+4*c) -: 8] = get_byte(s, w + 4*((c + w) % 4));
    return r;
  endfunction

  function automatic state_t inv_shift_rows(input state_t s);
    state_t r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(w+4*c) -: 8] = get_byte(s, w + 4*((c - w + 4) % 4));
    return r;
  endfunction

  function automatic state_t mix_columns(input state_t s);
    state_t r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = get_byte(s, 4*c);
      a1 = get_byte(s, 4*c + 1);
      a2 = get_byte(s, 4*c + 2);
      a3 = get_byte(s, 4*c + 3);
      r[127-32*c -: 32] = {gmul(a0, 4'h2) ^ gmul(a1, 4'h3) ^ a2 ^ a3,
                           a0 ^ gmul(a1, 4'h2) ^ gmul(a2, 4'h3) ^ a3,
                           a0 ^ a1 ^ gmul(a2, 4'h2) ^ gmul(a3, 4'h3),
                           gmul(a0, 4'h3) ^ a1 ^ a2 ^ gmul(a3, 4'h2)};
    end
    return r;
  endfunction

  function automatic state_t inv_mix_columns(input state_t s);
    state_t r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = get_byte(s, 4*c);
      a1 = get_byte(s, 4*c + 1);
      a2 = get_byte(s, 4*c + 2);
      a3 = get_byte(s, 4*c + 3);
      r[127-32*c -: 32] = {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
                           gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
                           gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
                           gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
    end
    return r;
  endfunction

endpackage

// File: rtl/iterative_round_engine_round_datapath.sv
// Combinational single AES round, forward or inverse; MixColumns is bypassed on the last round.
module round_datapath
  import iterative_round_engine_pkg::*;
(
  input  state_t    state,
  input  roundKey_t key,
  input  logic      inverse,
  input  logic      last,
  output state_t    out
);

  state_t fwd_sr;
  state_t fwd_mc;
  state_t inv_ark;

  always_comb begin
    fwd_sr  = shift_rows(sub_bytes(state));
    fwd_mc  = last ? fwd_sr : mix_columns(fwd_sr);
    // Inverse order keeps AddRoundKey before InvMixColumns so the plain key schedule is used.
    inv_ark = inv_sub_bytes(inv_shift_rows(state)) ^ key;
    if (inverse) out = last ? inv_ark : inv_mix_columns(inv_ark);
    else         out = fwd_mc ^ key;
  end

endmodule

// File: rtl/iterative_round_engine.sv
// Iterative AES core: one round datapath reused NUM_ROUNDS times per block, encrypt or
// decrypt chosen per block, valid/ready on both sides and round keys fetched by key_index.
module iterative_round_engine
  import iterative_round_engine_pkg::*;
#(
  parameter  int NUM_ROUNDS = AES128_ROUNDS,
  localparam int KIDX_W     = $clog2(NUM_ROUNDS + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              decrypt,
  input  state_t            in_state,
  output logic [KIDX_W-1:0] key_index,
  input  roundKey_t         round_key,
  output logic              out_valid,
  input  logic              out_ready,
  output state_t            out_state,
  output logic              busy
);

  // state | meaning
  // IDLE  | waiting for a block; offered block's initial key is presented
  // ROUND | one round per cycle, rnd = round being computed (1..NUM_ROUNDS)
  // DONE  | result held on out_state until out_ready; may accept next block same edge

  if (NUM_ROUNDS != AES128_ROUNDS && NUM_ROUNDS != AES192_ROUNDS &&
      NUM_ROUNDS != AES256_ROUNDS) begin : g_bad_rounds
    $error("iterative_round_engine: NUM_ROUNDS must be 10, 12 or 14");
  end

  localparam logic [KIDX_W-1:0] LAST_RND = KIDX_W'(NUM_ROUNDS);
  localparam logic [KIDX_W-1:0] ONE      = KIDX_W'(1);

  engine_fsm_t       fsm_q, fsm_d;
  logic [KIDX_W-1:0] rnd_q, rnd_d;
  state_t            state_q, state_d;
  state_t            round_out;
  logic              mode_q, mode_d;
  logic              out_valid_d;
  logic              last;
  logic              accept;

  assign last      = (rnd_q == LAST_RND);
  assign busy      = (fsm_q != IDLE);
  assign out_state = state_q;

  round_datapath u_round (
    .state   (state_q),
    .key     (round_key),
    .inverse (mode_q),
    .last    (last),
    .out     (round_out)
  );

  // Handshake and key-store address: kept apart from next-state so the external
  // key lookup never appears to loop back into the register inputs.
  always_comb begin
    in_ready  = 1'b0;
    key_index = decrypt ? LAST_RND : '0;
    unique case (fsm_q)
      IDLE:    in_ready = 1'b1;
      ROUND:   key_index = mode_q ? (LAST_RND - rnd_q) : rnd_q;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    if (reset) begin
      in_ready  = 1'b0;
      key_index = '0;
    end
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    fsm_d       = fsm_q;
    rnd_d       = rnd_q;
    state_d     = state_q;
    mode_d      = mode_q;
    out_valid_d = out_valid;
    unique case (fsm_q)
      IDLE: ;
      ROUND: begin
        state_d = round_out;
        if (last) begin
          fsm_d       = DONE;
          out_valid_d = 1'b1;
        end else begin
          rnd_d = rnd_q + ONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d       = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: fsm_d = IDLE;
    endcase
    // A new block overrides the DONE retire path when both happen on one edge.
    if (accept) begin
      state_d     = in_state ^ round_key;
      mode_d      = decrypt;
      rnd_d       = ONE;
      fsm_d       = ROUND;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q     <= IDLE;
      rnd_q     <= '0;
      state_q   <= '0;
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      rnd_q     <= rnd_d;
      state_q   <= state_d;
      mode_q    <= mode_d;
      out_valid <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_iterative_round_engine.sv
// Directed bench for iterative_round_engine: AES-128/192/256 instances fed from an
// expanded-key table built here, checked against FIPS-197 known-answer vectors.
module tb_iterative_round_engine;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  localparam logic [0:255][7:0] TB_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic             reset;
  logic [2:0]       in_valid, decrypt, out_ready;
  logic [2:0][127:0] in_state;
  wire  [2:0]       in_ready, out_valid, busy;
  wire  [2:0][3:0]  key_index;
  wire  [2:0][127:0] round_key, out_state;

  logic [127:0] ktab [3][16];

  int n_tests = 0;
  int n_fail  = 0;

  // Instance g runs NUM_ROUNDS = 10 + 2g (AES-128, -192, -256).
  for (genvar g = 0; g < 3; g++) begin : g_dut
    iterative_round_engine #(.NUM_ROUNDS(10 + 2*g)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .decrypt   (decrypt[g]),
      .in_state  (in_state[g]),
      .key_index (key_index[g]),
      .round_key (round_key[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g]),
      .busy      (busy[g])
    );
    assign round_key[g] = ktab[g][key_index[g]];
  end

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {TB_SBOX[w[31:24]], TB_SBOX[w[23:16]], TB_SBOX[w[15:8]], TB_SBOX[w[7:0]]};
  endfunction

  // FIPS-197 key expansion for key bytes 00,01,02,... of length 4*nk.
  task automatic expand_key(input int g, input int nk, input int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) ktab[g][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offer a block (caller has made in_ready reachable), then follow every round.
  task automatic accept_and_run(input int g, input int nr, input logic dec,
                                input logic [127:0] din, input logic [127:0] dexp,
                                input string tag);
    in_valid[g] = 1'b1;
    decrypt[g]  = dec;
    in_state[g] = din;
    #1;
    chk({tag, "_in_ready"}, in_ready[g], 1'b1);
    chk({tag, "_kidx0"}, key_index[g], dec ? 4'(nr) : 4'd0);
    tick();
    in_valid[g]  = 1'b0;
    out_ready[g] = 1'b0;
    for (int k = 1; k <= nr; k++) begin
      chk({tag, "_round"}, {out_valid[g], key_index[g]}, {1'b0, dec ? 4'(nr - k) : 4'(k)});
      tick();
    end
    chk({tag, "_out_valid"}, out_valid[g], 1'b1);
    chk({tag, "_out_state"}, out_state[g], dexp);
    chk({tag, "_busy"}, busy[g], 1'b1);
  endtask

  task automatic retire(input int g, input string tag);
    out_ready[g] = 1'b1;
    in_valid[g]  = 1'b0;
    #1;
    chk({tag, "_retire_ready"}, in_ready[g], 1'b1);
    tick();
    chk({tag, "_idle"}, {out_valid[g], busy[g]}, 2'b00);
    out_ready[g] = 1'b0;
  endtask

  initial begin
    int sent;
    int rcv;
    logic acc;
    logic ret;

    for (int g = 0; g < 3; g++)
      for (int r = 0; r < 16; r++) ktab[g][r] = '0;
    expand_key(0, 4, 10);
    expand_key(1, 6, 12);
    expand_key(2, 8, 14);

    // Reset with a decrypt block offered: key_index and in_ready must stay forced.
    reset     = 1'b1;
    in_valid  = '1;
    decrypt   = '1;
    out_ready = '0;
    in_state  = '0;
    repeat (3) tick();
    for (int g = 0; g < 3; g++) begin
      chk("rst_in_ready", in_ready[g], 1'b0);
      chk("rst_key_index", key_index[g], 4'd0);
      chk("rst_out_valid", out_valid[g], 1'b0);
      chk("rst_busy", busy[g], 1'b0);
      chk("rst_out_state", out_state[g], 128'h0);
    end
    in_valid = '0;
    decrypt  = '0;
    reset    = 1'b0;
    tick();

    // AES-128 encrypt and decrypt.
    accept_and_run(0, 10, 1'b0, PT, CT128, "enc128");
    retire(0, "enc128");
    accept_and_run(0, 10, 1'b1, CT128, PT, "dec128");
    retire(0, "dec128");

    // AES-192 and AES-256 round trips.
    accept_and_run(1, 12, 1'b0, PT, CT192, "enc192");
    retire(1, "enc192");
    accept_and_run(1, 12, 1'b1, CT192, PT, "dec192");
    retire(1, "dec192");
    accept_and_run(2, 14, 1'b0, PT, CT256, "enc256");
    retire(2, "enc256");
    accept_and_run(2, 14, 1'b1, CT256, PT, "dec256");
    retire(2, "dec256");

    // Backpressure in DONE with a block already offered, then same-edge retire + accept.
    accept_and_run(0, 10, 1'b0, PT, CT128, "bp_enc");
    in_valid[0] = 1'b1;
    decrypt[0]  = 1'b1;
    in_state[0] = CT128;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_valid", out_valid[0], 1'b1);
      chk("bp_out_state", out_state[0], CT128);
      chk("bp_in_ready", in_ready[0], 1'b0);
      tick();
    end
    out_ready[0] = 1'b1;
    accept_and_run(0, 10, 1'b1, CT128, PT, "bp_dec");
    retire(0, "bp_dec");

    // Reset while the block is at round 4, then a clean block afterwards.
    in_valid[0] = 1'b1;
    decrypt[0]  = 1'b0;
    in_state[0] = PT;
    tick();
    in_valid[0] = 1'b0;
    repeat (3) tick();
    chk("midrst_rnd4", key_index[0], 4'd4);
    reset = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready[0], 1'b0);
    chk("midrst_key_index", key_index[0], 4'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid[0], 1'b0);
    chk("midrst_busy", busy[0], 1'b0);
    chk("midrst_in_ready_after", in_ready[0], 1'b1);
    accept_and_run(0, 10, 1'b0, PT, CT128, "post_rst");
    retire(0, "post_rst");

    // Alternating encrypt/decrypt stream with random sink readiness.
    sent = 0;
    rcv  = 0;
    for (int cyc = 0; cyc < 600 && rcv < 8; cyc++) begin
      out_ready[0] = 1'($urandom_range(0, 1));
      in_valid[0]  = (sent < 8);
      decrypt[0]   = sent[0];
      in_state[0]  = sent[0] ? CT128 : PT;
      #1;
      acc = in_valid[0] && in_ready[0];
      ret = out_valid[0] && out_ready[0];
      if (ret) begin
        chk("alt_result", out_state[0], rcv[0] ? PT : CT128);
        rcv++;
      end
      tick();
      if (acc) sent++;
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    chk("alt_sent", sent, 8);
    chk("alt_received", rcv, 8);
    tick();
    chk("alt_final_idle", {out_valid[0], busy[0]}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
